// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between vga_timing_gen (master) and its downstream
// sync/coordinate delay stage (slave).
// Optional: VGA_FRAME_CNT_EN adds the 16-bit frame_cnt signal.
interface vga_timing_gen_if;
    logic       pclk_en;
    logic       DE;
    logic [9:0] x;
    logic [9:0] y;
    logic       h_sync;
    logic       v_sync;
    logic       line_start;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    modport master (
        input  pclk_en,
        output DE, x, y, h_sync, v_sync, line_start, frame_start, frame_cnt
    );
    modport slave (
        output pclk_en,
        input  DE, x, y, h_sync, v_sync, line_start, frame_start, frame_cnt
    );
`else
    modport master (
        input  pclk_en,
        output DE, x, y, h_sync, v_sync, line_start, frame_start
    );
    modport slave (
        output pclk_en,
        input  DE, x, y, h_sync, v_sync, line_start, frame_start
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters advanced by pclk_en, with
// horizontal and vertical phase FSMs driving DE and the sync outputs.
// All outputs are registered from the next-state position so DE, x, y and
// the syncs always describe the same pixel.
// Optional: VGA_FRAME_CNT_EN adds a 16-bit wrapping frame counter.
// H_TOTAL and V_TOTAL must each be <= 1024 (10-bit counters).
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input logic              clk,
    input logic              reset,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START   = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    phase_e     h_phase_q, h_phase_d;
    phase_e     v_phase_q, v_phase_d;
    logic       de_q, de_d;
    logic       h_sync_q, h_sync_d;
    logic       v_sync_q, v_sync_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       tick, h_wrap, v_wrap;

    // Phase advances when the count being entered hits the next boundary.
    function automatic phase_e next_phase(input phase_e cur, input logic [9:0] nxt,
                                          input logic [9:0] fp_s, input logic [9:0] sync_s,
                                          input logic [9:0] bp_s);
        phase_e n;
        n = cur;
        case (cur)
            PH_ACTIVE: if (nxt == fp_s)   n = PH_FP;
            PH_FP:     if (nxt == sync_s) n = PH_SYNC;
            PH_SYNC:   if (nxt == bp_s)   n = PH_BP;
            PH_BP:     if (nxt == 10'd0)  n = PH_ACTIVE;
            default:   n = PH_ACTIVE;
        endcase
        return n;
    endfunction

    assign tick   = vif.pclk_en;
    assign h_wrap = tick && (h_cnt_q == H_LAST);
    assign v_wrap = h_wrap && (v_cnt_q == V_LAST);

    // Next pixel/line position; lines only move on the horizontal wrap.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        end
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    // Horizontal and vertical phase FSMs, stepped on ticks / line wraps.
    always_comb begin
        h_phase_d = h_phase_q;
        v_phase_d = v_phase_q;
        if (tick) begin
            h_phase_d = next_phase(h_phase_q, h_cnt_d, H_FP_START, H_SYNC_START, H_BP_START);
        end
        if (h_wrap) begin
            v_phase_d = next_phase(v_phase_q, v_cnt_d, V_FP_START, V_SYNC_START, V_BP_START);
        end
    end

    // Level outputs only change on a tick, so the reset position keeps DE low
    // until the raster actually starts moving.
    always_comb begin
        de_d          = de_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
        if (tick) begin
            de_d     = (h_phase_d == PH_ACTIVE) && (v_phase_d == PH_ACTIVE);
            h_sync_d = (h_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            v_sync_d = (v_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Position, phase and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_phase_q     <= PH_ACTIVE;
            v_phase_q     <= PH_ACTIVE;
            de_q          <= 1'b0;
            h_sync_q      <= ~SYNC_POL;
            v_sync_q      <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_phase_q     <= h_phase_d;
            v_phase_q     <= v_phase_d;
            de_q          <= de_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.DE          = de_q;
    assign vif.x           = h_cnt_q;
    assign vif.y           = v_cnt_q;
    assign vif.h_sync      = h_sync_q;
    assign vif.v_sync      = v_sync_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frames seen since reset; wraps naturally at 16 bits.
    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(v_wrap);
    end

    // Frame counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vif.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance for line-level checks
// and a tiny active-high-sync instance that wraps many frames quickly under
// random pixel ticks. Both are compared every cycle against a position model.
module tb_vga_timing_gen;
    localparam int D_HV = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VV = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
    localparam int D_HT = D_HV + D_HF + D_HS + D_HB;
    localparam int D_VT = D_VV + D_VF + D_VS + D_VB;
    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   chk_en = 1'b0;

    vga_timing_gen_if dif();
    vga_timing_gen_if sif();

    vga_timing_gen dut_d (
        .clk   (clk),
        .reset (reset),
        .vif   (dif)
    );

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b1)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .vif   (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected outputs follow directly from the raster position and the timing rules.
    task automatic cmp(input string tag, input int h, input int v, input bit rs,
                       input bit ls, input bit fs,
                       input int hv, input int hf, input int hs_w,
                       input int vv, input int vf, input int vs_w, input bit pol,
                       input logic de_a, input logic [9:0] x_a, input logic [9:0] y_a,
                       input logic hs_a, input logic vs_a, input logic ls_a, input logic fs_a);
        logic e_de, e_hs, e_vs;
        e_de = !rs && (h < hv) && (v < vv);
        e_hs = (h >= hv + hf && h < hv + hf + hs_w) ? pol : !pol;
        e_vs = (v >= vv + vf && v < vv + vf + vs_w) ? pol : !pol;
        chk({tag, "_x"}, x_a, h);
        chk({tag, "_y"}, y_a, v);
        chk({tag, "_de"}, de_a, e_de);
        chk({tag, "_hsync"}, hs_a, e_hs);
        chk({tag, "_vsync"}, vs_a, e_vs);
        chk({tag, "_line_start"}, ls_a, ls);
        chk({tag, "_frame_start"}, fs_a, fs);
    endtask

    // Reference raster positions (modulo counters) plus reset-position flag.
    int dh = 0, dv = 0, sh = 0, sv = 0, s_ticks = 0, s_fcnt = 0;
    bit drs = 1, srs = 1, dls = 0, dfs = 0, sls = 0, sfs = 0, s_tick = 0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            dh = 0; dv = 0; drs = 1; dls = 0; dfs = 0;
            sh = 0; sv = 0; srs = 1; sls = 0; sfs = 0; s_tick = 0; s_fcnt = 0;
        end else begin
            cyc++;
            dls = 0; dfs = 0; sls = 0; sfs = 0;
            if (dif.pclk_en) begin
                drs = 0;
                dls = (dh == D_HT - 1);
                dfs = dls && (dv == D_VT - 1);
                if (dls) dv = (dv + 1) % D_VT;
                dh = (dh + 1) % D_HT;
            end
            s_tick = sif.pclk_en;
            if (sif.pclk_en) begin
                srs = 0;
                s_ticks++;
                sls = (sh == S_HT - 1);
                sfs = sls && (sv == S_VT - 1);
                if (sls) sv = (sv + 1) % S_VT;
                sh = (sh + 1) % S_HT;
                if (sfs) s_fcnt = (s_fcnt + 1) % 65536;
            end
        end
    end

    // Per-cycle compare plus frame-level measurements on the small instance.
    int s_last_fs = -1, s_vs_cnt = 0, nfr = 0;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("d", dh, dv, drs, dls, dfs, D_HV, D_HF, D_HS, D_VV, D_VF, D_VS, 1'b0,
                dif.DE, dif.x, dif.y, dif.h_sync, dif.v_sync, dif.line_start, dif.frame_start);
            cmp("s", sh, sv, srs, sls, sfs, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS, 1'b1,
                sif.DE, sif.x, sif.y, sif.h_sync, sif.v_sync, sif.line_start, sif.frame_start);
`ifdef VGA_FRAME_CNT_EN
            chk("s_frame_cnt", sif.frame_cnt, 32'(s_fcnt));
`endif
            if (!reset) begin
                s_last_fs = -1;
                s_vs_cnt  = 0;
            end else if (sif.frame_start) begin
                if (s_last_fs >= 0) begin
                    chk("s_frame_period", s_ticks - s_last_fs, 165);
                    chk("s_vsync_ticks", s_vs_cnt, 30);
                    nfr++;
                end
                s_last_fs = s_ticks;
                s_vs_cnt  = 0;
            end else if (s_tick && sif.v_sync) begin
                s_vs_cnt++;
            end
        end
    end

    // Small instance gets random ticks throughout.
    initial forever begin
        @(negedge clk);
        sif.pclk_en = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int de_cnt, hs_cnt, ls_cnt, last_ls, nls;
        bit found;
        dif.pclk_en = 1'b1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_x", dif.x, 0);
        chk("rst_y", dif.y, 0);
        chk("rst_de", dif.DE, 0);
        chk("rst_hsync", dif.h_sync, 1);
        chk("rst_vsync", dif.v_sync, 1);
        chk("rst_s_hsync", sif.h_sync, 0);
        #3 reset = 1'b1;

        // One full line at a tick every clock.
        de_cnt = 0; hs_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("first_tick_x", dif.x, 1);
            if (dif.DE) de_cnt++;
            if (!dif.h_sync) hs_cnt++;
            if (dif.line_start) ls_cnt++;
            if (!dif.h_sync && hs_cnt == 1) chk("hsync_start_x", dif.x, 656);
        end
        chk("line_de_ticks", de_cnt, 640);
        chk("line_hsync_ticks", hs_cnt, 96);
        chk("line_start_count", ls_cnt, 1);
        chk("line_end_x", dif.x, 0);
        chk("line_end_y", dif.y, 1);

        // Tick every 4th clock: line period stretches to 3200 clocks.
        last_ls = -1; nls = 0;
        for (int i = 0; i < 6600; i++) begin
            @(posedge clk); #1;
            if (dif.line_start) begin
                if (last_ls >= 0) chk("line_period_div4", cyc - last_ls, 3200);
                last_ls = cyc;
                nls++;
            end
            dif.pclk_en = (i % 4 == 3);
        end
        chk("line_starts_div4", nls >= 2, 1);

        // Asynchronous reset in the middle of a line.
        dif.pclk_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (dif.x == 10'd300) found = 1'b1;
        end
        chk("reach_x300", found, 1);
        #3 reset = 1'b0;
        #1;
        chk("async_x", dif.x, 0);
        chk("async_y", dif.y, 0);
        chk("async_de", dif.DE, 0);
        chk("async_hsync", dif.h_sync, 1);
        chk("async_s_vsync", sif.v_sync, 0);
        @(negedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        chk("restart_x", dif.x, 1);
        chk("restart_y", dif.y, 0);

        repeat (3000) @(posedge clk);
        @(negedge clk);
        chk("small_frames_seen", nfr >= 5, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
